data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory port. The core drives address, read enable, write enable and write data; this block returns read data.
- Contains word-addressed data RAM plus a small MMIO window: a byte TX FIFO with a streaming output, a status register and a free-running cycle counter.
- Sits beside the core at top level. Its streaming TX output feeds a future UART/trace sink.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words (power of 2).
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, 2..128).
- MMIO_BASE_HI, 16'hFFFF, value of addr[31:16] that selects the MMIO window.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_addr  in  32  byte address from core; addr[1:0] ignored.
- i_r_en  in  1  read enable.
- i_w_en  in  1  write enable.
- i_w_data  in  32  write data.
- o_r_data  out  32  read data, combinational, valid in the same cycle as i_r_en.
- o_tx_valid  out  1  TX FIFO non-empty.
- o_tx_data  out  8  TX FIFO head byte.
- i_tx_ready  in  1  sink accepts head byte.

Behaviour:
- One clock; i_rst is asynchronous and active-high.
- Decode: MMIO selected when i_addr[31:16]==MMIO_BASE_HI; all other addresses go to RAM.
- RAM index is i_addr[clog2(RAM_WORDS)+1:2]. Upper bits are ignored, so addresses alias.
- Read latency 0 (core captures at end of its MEM cycle):
  - o_r_data is a combinational function of i_addr and current state.
  - o_r_data = 0 whenever i_r_en=0.
  - Reads have no side effects.
- Writes commit at posedge when i_w_en=1.
- i_r_en and i_w_en both high: read returns the pre-write value; the write still commits.
- RAM contents are not reset.
- MMIO offsets (i_addr[15:0]):
  - 0x0000 TXDATA: write pushes i_w_data[7:0] to the FIFO. If the FIFO is full with no pop that cycle, the byte is dropped and the sticky overflow bit is set. Read returns 0.
  - 0x0004 STATUS, read fields:
    - bit0 = full
    - bit1 = empty
    - bit2 = overflow (sticky)
    - bits[15:8] = count
    - other bits 0
  - 0x0004 STATUS, write: i_w_data[2]=1 clears overflow; other bits are ignored.
  - 0x0008 CYCLE: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0. A write loads i_w_data at the edge, then increments from the next edge.
  - Other offsets: read 0, writes ignored.
- TX FIFO:
  - o_tx_valid = !empty; o_tx_data = head, or 0 when empty.
  - Pop on posedge when o_tx_valid & i_tx_ready.
  - Push and pop in the same cycle: both take effect; count unchanged. This holds when full too: the push is accepted, no overflow.
  - Push into empty FIFO: o_tx_valid rises the cycle after the write edge (no write-to-output bypass).
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Reset values:
  - FIFO empty, pointers 0, overflow 0, cycle counter 0.
  - o_tx_valid=0, o_tx_data=0, o_r_data=0.
- Reset mid-operation: asynchronously discards FIFO contents and any pending pop, and clears the counter. RAM is untouched.

Decomposition:
- Package data_mem_map:
  - MMIO offset constants: TXDATA, STATUS, CYCLE.
  - STATUS bit positions.
  - Enum for the address region: RAM, MMIO.
- Sub-module tx_fifo, parameterised by depth and width:
  - Inputs: push, push_data, pop.
  - Outputs: head, full, empty, count.
  - Reused for a future RX path.

Test Plan:
- RAM round trip: write 0xDEADBEEF @0x00000010, then read @0x00000010 -> 0xDEADBEEF. Read @0x00001010 (alias, RAM_WORDS=1024) -> 0xDEADBEEF. i_r_en=0 -> o_r_data=0.
- FIFO fill/drain with i_tx_ready=0:
  - Write 0x41..0x48 to TXDATA -> STATUS=0x00000801 (count 8, full).
  - Ninth write 0x49 -> STATUS bit2 set, byte dropped.
  - Raise i_tx_ready -> o_tx_data sequence 0x41..0x48 on 8 consecutive cycles, then o_tx_valid=0, STATUS=0x00000006.
  - Write STATUS 0x4 -> STATUS=0x00000002.
- Full push+pop: FIFO full, i_tx_ready=1, write 0x50 to TXDATA same cycle -> count stays 8, overflow stays 0, 0x50 appears last.
- Cycle counter: read CYCLE on consecutive cycles -> values differ by 1. Write 0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on the next three cycles.
- Async reset: assert i_rst between clock edges with 3 bytes queued -> o_tx_valid=0 immediately, STATUS=0x00000002, CYCLE=0. Previously written RAM word still reads back.
- Same-cycle read+write to the same RAM word (old 0x1, new 0x2) -> o_r_data=0x1 that cycle, 0x2 the next.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Address map for the data-memory responder: MMIO offsets,
// STATUS field positions and the region selector.
package data_mem_map;

    localparam logic [15:0] OFF_TXDATA = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CYCLE  = 16'h0008;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 8;

    typedef enum logic {
        REG_RAM,
        REG_MMIO
    } region_e;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with registered head; a push while full is
// accepted only if a pop retires the head in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign o_full  = (cnt_q == CW'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign o_count = cnt_q;
    assign o_head  = o_empty ? '0 : mem_q[rd_q];

    always_comb begin
        pop_ok  = i_pop && !o_empty;
        push_ok = i_push && (!o_full || pop_ok);
        wr_d    = wr_q + AW'(push_ok);
        rd_d    = rd_q + AW'(pop_ok);
        cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO window holding a TX byte
// FIFO, status register and free-running cycle counter.
module data_mem_responder
    import data_mem_map::*;
#(
    parameter int          RAM_WORDS    = 1024,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] MMIO_BASE_HI = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic        i_r_en,
    input  logic        i_w_en,
    input  logic [31:0] i_w_data,
    output logic [31:0] o_r_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    ram_q [RAM_WORDS];
    logic [RAW-1:0] ram_idx;
    region_e        region;
    logic [15:0]    off;
    logic           ram_we, tx_push, tx_pop, st_wr, cyc_wr;
    logic           ovf_q, ovf_d;
    logic [31:0]    cyc_q, cyc_d;
    logic [31:0]    status;
    logic [7:0]     fifo_head;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           unused_addr;

    assign unused_addr = ^i_addr[1:0];
    assign ram_idx     = i_addr[RAW+1:2];
    assign region      = (i_addr[31:16] == MMIO_BASE_HI) ? REG_MMIO : REG_RAM;
    assign off         = {i_addr[15:2], 2'b00};

    assign ram_we  = i_w_en && (region == REG_RAM);
    assign tx_push = i_w_en && (region == REG_MMIO) && (off == OFF_TXDATA);
    assign st_wr   = i_w_en && (region == REG_MMIO) && (off == OFF_STATUS);
    assign cyc_wr  = i_w_en && (region == REG_MMIO) && (off == OFF_CYCLE);
    assign tx_pop  = o_tx_valid && i_tx_ready;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (tx_push),
        .i_push_data (i_w_data[7:0]),
        .i_pop       (tx_pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

    assign o_tx_valid = !fifo_empty;
    assign o_tx_data  = fifo_head;

    always_comb begin
        status                     = '0;
        status[ST_FULL]            = fifo_full;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_OVF]             = ovf_q;
        status[ST_CNT_LO+:8]       = 8'(fifo_count);
    end

    always_comb begin
        o_r_data = '0;
        if (i_r_en) begin
            unique case (region)
                REG_RAM:  o_r_data = ram_q[ram_idx];
                REG_MMIO: begin
                    case (off)
                        OFF_STATUS: o_r_data = status;
                        OFF_CYCLE:  o_r_data = cyc_q;
                        default:    o_r_data = '0;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (tx_push && fifo_full && !tx_pop) begin
            ovf_d = 1'b1;
        end
        if (st_wr && i_w_data[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        cyc_d = cyc_wr ? i_w_data : cyc_q + 32'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
            cyc_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            cyc_q <= cyc_d;
        end
    end

    // RAM is deliberately outside the reset domain
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= i_w_data;
        end
    end

endmodule
